// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the display arbiter
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    localparam int NUM_REQ = 3;
    localparam int DIGITS  = 6;
    localparam int DIGIT_W = 4;
    localparam int DATA_W  = 8;
    localparam int VAL_W   = DIGITS * DIGIT_W;

    function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] next3(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - three-way round-robin pick, searching last+1, last+2, last
module rr_pick3
    import display_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        cand1  = next3(last);
        cand2  = next3(cand1);
        valid  = |req;
        winner = last;
        if (|(req & onehot3(cand1))) begin
            winner = cand1;
        end else if (|(req & onehot3(cand2))) begin
            winner = cand2;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - arbitrates three requesters for a six-digit display
// with a guaranteed minimum ownership time and round-robin fairness.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [2:0]        req,
    input  logic [VAL_W-1:0]  req0_val,
    input  logic [VAL_W-1:0]  req1_val,
    input  logic [VAL_W-1:0]  req2_val,
    output logic [2:0]        gnt,
    output logic [1:0]        owner_id,
    output logic              busy,
    output logic [DATA_W-1:0] data5,
    output logic [DATA_W-1:0] data4,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data0
);

    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [VAL_W-1:0] data_q, data_d;

    logic             pick_valid;
    logic [1:0]       pick_winner;
    logic [VAL_W-1:0] win_val, own_val;
    logic             own_req, other_req, take_new;

    rr_pick3 u_pick (
        .req    (req),
        .last   (owner_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        case (pick_winner)
            2'd1:    win_val = req1_val;
            2'd2:    win_val = req2_val;
            default: win_val = req0_val;
        endcase
        case (owner_q)
            2'd1:    own_val = req1_val;
            2'd2:    own_val = req2_val;
            default: own_val = req0_val;
        endcase
    end

    // The HOLD expiry edge applies the OWN rules directly, so under contention
    // each owner keeps the display for exactly HOLD_CYCLES cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        data_d    = data_q;
        take_new  = 1'b0;
        own_req   = |(req & onehot3(owner_q));
        other_req = |(req & ~onehot3(owner_q));

        case (state_q)
            ST_IDLE: begin
                take_new = pick_valid;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    if (other_req) begin
                        take_new = 1'b1;
                    end else if (own_req) begin
                        state_d = ST_OWN;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OWN: begin
                if (other_req) begin
                    take_new = 1'b1;
                end else if (!own_req) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        if (take_new) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            gnt_d   = onehot3(pick_winner);
            owner_d = pick_winner;
            data_d  = win_val;
        end else if (state_q != ST_IDLE && own_req) begin
            data_d = own_val;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            owner_q <= 2'd2;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            data_q  <= data_d;
        end
    end

    localparam int PAD = DATA_W - DIGIT_W;

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = (state_q != ST_IDLE);
    assign data5    = {{PAD{1'b0}}, data_q[23:20]};
    assign data4    = {{PAD{1'b0}}, data_q[19:16]};
    assign data3    = {{PAD{1'b0}}, data_q[15:12]};
    assign data2    = {{PAD{1'b0}}, data_q[11:8]};
    assign data1    = {{PAD{1'b0}}, data_q[7:4]};
    assign data0    = {{PAD{1'b0}}, data_q[3:0]};

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50000000, the minimum number of sys_clk cycles a granted requester owns the display (valid range >= 1).
REQ-002 SHALL have port sys_clk  input  1  the single system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  3  per-requester display request, bit i = requester i, level-held.
REQ-005 SHALL have ports req0_val, req1_val, req2_val  input  24  six hex digits per requester; [23:20] is the leftmost digit.
REQ-006 SHALL have port gnt  output  3  one-hot grant, or all-zero when no owner.
REQ-007 SHALL have port owner_id  output  2  index of the current/last owner, range 0-2.
REQ-008 SHALL have port busy  output  1  high in HOLD or OWN.
REQ-009 SHALL have ports data5..data0  output  8 each  digit values for the six-digit display; data5 = val[23:20] ... data0 = val[3:0], bits [7:4] always 0.

Function
REQ-010 SHALL implement FSM states IDLE, HOLD, OWN.
REQ-011 IDLE: if any req bit is high at edge N, SHALL select a winner by round-robin, enter HOLD, and drive gnt one-hot and owner_id = winner from cycle N+1.
REQ-012 Round-robin search order SHALL be (last+1, last+2, last) mod 3, where last = owner_id.
REQ-013 HOLD: hold counter SHALL clear on entry and increment each cycle; after HOLD_CYCLES cycles in HOLD, SHALL go to OWN.
REQ-014 HOLD SHALL NOT end early if the owner drops req; the minimum display time is guaranteed.
REQ-015 HOLD SHALL NOT be preempted by other requests.
REQ-016 OWN, if another req bit is high: SHALL switch directly to HOLD with the round-robin winner, gnt changing in one cycle with no all-zero gap and the counter cleared.
REQ-017 OWN, if only the owner's req is high: SHALL stay in OWN.
REQ-018 OWN, if no req is high: SHALL go to IDLE, with gnt = 0 from the next cycle.
REQ-019 Data: while gnt[i] and req[i] are high, SHALL register req{i}_val each cycle onto data5..data0 (1-cycle latency).
REQ-020 Data SHALL freeze at its last value when the owner's req is low or in IDLE; the display is never blanked by the arbiter.
REQ-021 At the grant cycle N+1, data SHALL reflect the winner's value sampled at edge N.
REQ-022 Simultaneous requests SHALL be resolved only by REQ-012; a requester at the same priority is never starved, with each waiting at most 2 ownership periods.
REQ-023 With HOLD_CYCLES = 1, HOLD SHALL last exactly one cycle.
REQ-024 The hold counter SHALL be sized to hold HOLD_CYCLES and SHALL saturate, never wrap.

Reset
REQ-025 While sys_rst is high at an edge, SHALL force: state = IDLE, gnt = 0, busy = 0, owner_id = 2 (so the first search order is 0,1,2), counter = 0, data5..data0 = 0.
REQ-026 Reset asserted mid-HOLD/OWN SHALL take effect at the next edge regardless of req; after release, arbitration restarts from IDLE.
REQ-027 SHALL have no initial blocks and no asynchronous paths.

Structure
REQ-028 Shared package display_pkg SHALL hold: state encoding (IDLE/HOLD/OWN), NUM_REQ = 3, DIGITS = 6, digit width 4, and the display data port width 8.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick3 (inputs req[2:0], last[1:0]; outputs valid, winner[1:0]); all other logic SHALL be in display_arbiter.
REQ-030 data5..data0 SHALL connect directly to the six-digit display block's data inputs.

Verification (bench HOLD_CYCLES = 4)
REQ-031 Reset release, no req for 10 cycles -> gnt = 000, busy = 0, owner_id = 2, all data = 0.
REQ-032 req = 001 with req0_val = 0x12AB3F at edge N -> gnt = 001 at N+1; data5..data0 = 1,2,A,B,3,F at N+1; OWN at N+5.
REQ-033 req = 111 from IDLE -> owner sequence 0,1,2,0, each for exactly 4 cycles; gnt never 000 between owners.
REQ-034 req0 raised, then dropped 1 cycle after grant -> gnt = 001 for the full 4 cycles, data frozen, then IDLE with gnt = 000 and data still showing the last value.
REQ-035 req = 010 owner; req0_val changes 0x000001 -> 0x000002 while owner is 1 -> data unaffected; change req1_val to 0x0000FF -> data1 = F, data0 = F one cycle later.
REQ-036 sys_rst pulsed for 1 cycle in OWN with owner 1 -> next cycle gnt = 000, data = 0, owner_id = 2; with req = 011 held, the next grant goes to 0.
